// File: rtl/dct_transpose_ctrl_if.sv
// Row-in / column-out control bundle between the transpose sequencer and its neighbours.
// master = controller side (drives memory strobes and column flags), slave = surroundings.
interface dct_transpose_ctrl_if #(
    parameter int BLK_CNT_W = 16
);
    logic                 row_valid;
    logic                 row_ready;
    logic                 mem_wr;
    logic                 mem_rst;
    logic                 col_valid;
    logic [2:0]           col_idx;
    logic                 block_done;
    logic [BLK_CNT_W-1:0] blk_count;
    logic                 busy;

    modport master (
        input  row_valid,
        output row_ready, mem_wr, mem_rst, col_valid, col_idx, block_done, blk_count, busy
    );

    modport slave (
        output row_valid,
        input  row_ready, mem_wr, mem_rst, col_valid, col_idx, block_done, blk_count, busy
    );
endinterface

// File: rtl/dct_transpose_ctrl.sv
// Sequences an 8x8 transpose buffer: 8 row writes, 1 pointer-realign cycle, 8 column reads.
// Columns appear 1 cycle after their read; rows are refused outside FILL, column side has no stall.
module dct_transpose_ctrl #(
    parameter int N         = 8,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    dct_transpose_ctrl_if.master bus
);
    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic [1:0] {FILL, SYNC, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [2:0]           row_cnt_q, row_cnt_d;
    logic [2:0]           rd_cnt_q, rd_cnt_d;
    logic                 col_valid_q;
    logic [2:0]           col_idx_q;
    logic                 block_done_q;
    logic [BLK_CNT_W-1:0] blk_count_q;
    logic                 row_ready_c;
    logic                 wr_c;
    logic                 sync_c;
    logic                 drain_last;

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        row_ready_c = 1'b0;
        wr_c        = 1'b0;
        sync_c      = 1'b0;
        unique case (state_q)
            FILL: begin
                row_ready_c = 1'b1;
                wr_c        = bus.row_valid;
                if (bus.row_valid) begin
                    if (row_cnt_q == LAST) begin
                        row_cnt_d = 3'd0;
                        state_d   = SYNC;
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
            end
            // Write pointer has already wrapped, so this pulse only realigns the read pointer.
            SYNC: begin
                sync_c  = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = 3'd0;
                    state_d  = FILL;
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign drain_last = (state_q == DRAIN) && (rd_cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= FILL;
            row_cnt_q    <= 3'd0;
            rd_cnt_q     <= 3'd0;
            col_valid_q  <= 1'b0;
            col_idx_q    <= 3'd0;
            block_done_q <= 1'b0;
            blk_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            col_valid_q  <= (state_q == DRAIN);
            col_idx_q    <= rd_cnt_q;
            block_done_q <= drain_last;
            if (drain_last) begin
                blk_count_q <= blk_count_q + BLK_CNT_W'(1);
            end
        end
    end

    assign bus.row_ready  = row_ready_c & ~reset_i;
    assign bus.mem_wr     = wr_c & ~reset_i;
    assign bus.mem_rst    = reset_i | sync_c;
    assign bus.col_valid  = col_valid_q;
    assign bus.col_idx    = col_idx_q;
    assign bus.block_done = block_done_q;
    assign bus.blk_count  = blk_count_q;
    assign bus.busy       = (state_q != FILL) | col_valid_q;
endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// Drives two controllers (16-bit and 2-bit block counters) against a block_mem model
// and a schedule-level reference of the fill / realign / drain sequence.
module tb_dct_transpose_ctrl;
    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    logic tb_rv = 1'b0;
    always #5 clk = ~clk;

    dct_transpose_ctrl_if #(.BLK_CNT_W(16)) if1 ();
    dct_transpose_ctrl_if #(.BLK_CNT_W(2))  if2 ();
    assign if1.row_valid = tb_rv;
    assign if2.row_valid = tb_rv;

    dct_transpose_ctrl #(.N(8), .BLK_CNT_W(16)) dut  (.clk_i(clk), .reset_i(tb_rst), .bus(if1));
    dct_transpose_ctrl #(.N(8), .BLK_CNT_W(2))  dut2 (.clk_i(clk), .reset_i(tb_rst), .bus(if2));

    // block_mem behaviour, driven by the 16-bit instance
    logic [7:0] rd [8];
    logic [7:0] mm [8][8];
    logic [7:0] mo [8];
    logic [2:0] mx = 3'd0;
    logic [2:0] my = 3'd0;
    always @(posedge clk) begin
        if (if1.mem_rst) begin
            mx <= 3'd0;
            my <= 3'd0;
        end else if (if1.mem_wr) begin
            for (int c = 0; c < 8; c++) mm[mx][c] <= rd[c];
            mx <= mx + 3'd1;
        end else begin
            for (int j = 0; j < 8; j++) mo[j] <= mm[j][my];
            my <= my + 3'd1;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference: m_drain = -1 while filling, else cycles since the 8th row (0 = realign, 1..8 = reads)
    int m_drain = -1;
    int m_rows = 0;
    bit m_cv = 1'b0;
    int m_ci = 0;
    int m_blocks = 0;
    bit pat = 1'b0;
    logic [7:0] cur [8][8];
    logic [7:0] drn [8][8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rv, input bit rst);
        logic [63:0] col_obs, col_exp;
        bit exp_rr;
        tb_rv = rv;
        tb_rst = rst;
        for (int c = 0; c < 8; c++) rd[c] = pat ? 8'(8 * m_rows + c) : 8'($urandom);
        #1;
        exp_rr = !rst && (m_drain < 0);
        chk("row_ready", 64'(if1.row_ready), 64'(exp_rr));
        chk("mem_wr", 64'(if1.mem_wr), 64'(exp_rr && rv));
        chk("mem_rst", 64'(if1.mem_rst), 64'(rst || m_drain == 0));
        chk("col_valid", 64'(if1.col_valid), 64'(m_cv));
        chk("block_done", 64'(if1.block_done), 64'(m_cv && m_ci == 7));
        chk("busy", 64'(if1.busy), 64'(m_drain >= 0 || m_cv));
        chk("blk_count", 64'(if1.blk_count), 64'(m_blocks[15:0]));
        chk("blk_count_w2", 64'(if2.blk_count), 64'(m_blocks[1:0]));
        chk("w2_col_valid", 64'(if2.col_valid), 64'(m_cv));
        if (m_cv) begin
            chk("col_idx", 64'(if1.col_idx), 64'(m_ci));
            for (int j = 0; j < 8; j++) begin
                col_obs[8*j +: 8] = mo[j];
                col_exp[8*j +: 8] = drn[j][m_ci];
            end
            chk("col_data", col_obs, col_exp);
        end
        @(posedge clk);
        if (rst) begin
            m_drain = -1;
            m_rows = 0;
            m_cv = 1'b0;
            m_ci = 0;
            m_blocks = 0;
        end else begin
            m_cv = (m_drain >= 1) && (m_drain <= 8);
            m_ci = m_drain - 1;
            if (m_cv && m_ci == 7) m_blocks++;
            if (m_drain >= 0) begin
                m_drain = (m_drain == 8) ? -1 : m_drain + 1;
            end else if (rv) begin
                for (int c = 0; c < 8; c++) cur[m_rows][c] = rd[c];
                m_rows++;
                if (m_rows == 8) begin
                    drn = cur;
                    m_rows = 0;
                    m_drain = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        // reset held, then idle
        repeat (3) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);

        // reset while draining column 3: block abandoned
        pat = 1'b1;
        repeat (8) cyc(1'b1, 1'b0);
        for (int i = 0; i < 20 && m_drain != 4; i++) cyc(1'b0, 1'b0);
        chk("reach_drain_rd3", 64'(m_drain), 64'd4);
        cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b0, 1'b0);

        // single contiguous block, element = 8r+c
        repeat (8) cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);

        // gapped input, random data
        pat = 1'b0;
        for (int i = 0; i < 15; i++) cyc(i % 2 == 0, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);

        // back-to-back blocks
        repeat (3 * 17) cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);
        chk("b2b_blocks", 64'(if1.blk_count), 64'd5);

        // random row_valid
        repeat (300) cyc(1'($urandom_range(0, 1)), 1'b0);
        repeat (12) cyc(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dct_transpose_ctrl.md
Name: dct_transpose_ctrl

Overview:
- Sequencer for the 8x8 transpose buffer (`block_mem`) between the row-pass 1D DCT and the column-pass 1D DCT.
- Accepts 8 row-DCT result vectors and drives `block_mem` to store them as rows.
- Then drives `block_mem` to read the 8 columns back, and marks each column valid for the column-pass DCT.
- Keeps `block_mem`'s internal row/column pointers aligned; reports block completion and a running block count.

Parameters:
- `N`, 8, block dimension; fixed at 8 because `block_mem` is 8x8. Any other value is unsupported.
- `BLK_CNT_W`, 16, width of the completed-block counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `row_valid`  in  1  row-pass DCT presents one 8-coefficient row this cycle.
- `row_ready`  out  1  controller can accept a row; a row is transferred when `row_valid` and `row_ready` are both high.
- `mem_wr`  out  1  drives `block_mem` `wr`.
- `mem_rst`  out  1  drives `block_mem` `reset`; realigns its pointers.
- `col_valid`  out  1  `block_mem` `out0..out7` hold a valid column this cycle.
- `col_idx`  out  3  index of the column on `out0..out7` (0..7).
- `block_done`  out  1  one-cycle pulse, coincident with the `col_valid` of column 7.
- `blk_count`  out  `BLK_CNT_W`  number of completed blocks, wraps modulo 2^`BLK_CNT_W`.
- `busy`  out  1  high in SYNC, in DRAIN, or while `col_valid` is high.

Behaviour:
- Memory facts the controller relies on:
  - `wr`=1 writes a row at the internal row pointer x, then x increments.
  - `wr`=0 reads column y into registered outputs, then y increments; this happens every cycle `wr` is low.
  - `reset` zeroes x and y.
- Reset values (`reset` high at a rising edge):
  - state=FILL, `row_cnt`=0, `rd_cnt`=0, `blk_count`=0.
  - `col_valid`=0, `col_idx`=0, `block_done`=0, `row_ready`=0.
  - `mem_rst`=1 while `reset` is high (`mem_rst` = `reset` OR internal sync pulse). `mem_wr`=0.
  - Reset mid-FILL or mid-DRAIN abandons the block; no `block_done` for it.
- FILL state:
  - `row_ready`=1 and `mem_wr`=`row_valid` (combinational).
  - Each accepted row increments `row_cnt`.
  - On the 8th acceptance (`row_cnt`=7 and `row_valid`): `row_cnt`←0, go to SYNC.
  - Cycles with `row_valid`=0 leave `mem_wr` low. The memory performs a spurious read and y drifts; this is tolerated because SYNC realigns y and `col_valid` stays low.
- SYNC state, exactly 1 cycle:
  - `mem_rst`=1, `mem_wr`=0, `row_ready`=0.
  - x has already wrapped to 0, so the pulse is harmless to the write side.
  - Go to DRAIN.
- DRAIN state, exactly 8 cycles:
  - `mem_wr`=0, `row_ready`=0.
  - `rd_cnt` counts 0..7; at `rd_cnt`=7, `rd_cnt`←0 and go to FILL.
- Output timing:
  - Read latency is 1 cycle: `col_valid` and `col_idx` are registered copies of (state==DRAIN, `rd_cnt`).
  - The column read in DRAIN cycle k is on `out0..out7` in cycle k+1 with `col_idx`=k.
  - Column 7 appears in the first cycle back in FILL. If a row is accepted that cycle, `mem_wr`=1 freezes the memory outputs, so column 7 stays valid.
- No backpressure from the column-pass DCT: it must accept 8 consecutive columns. The memory read cannot be stalled.
- `block_done` is registered: high when `col_valid`=1 and `col_idx`=7. `blk_count` increments in that same cycle, wrapping all-ones→0.
- Throughput: at least 17 cycles per block (8 fill + 1 sync + 8 drain). Back-to-back blocks are supported with no extra bubble.

Test Plan:
- Reset: hold `reset` 3 cycles → `mem_rst`=1 during reset; after release `row_ready`=1, `col_valid`=0, `blk_count`=0, `mem_wr`=0 while `row_valid`=0.
- Single block, contiguous: `row_valid`=1 cycles 0-7 with row r element c = 8r+c → `mem_wr`=1 cycles 0-7; `mem_rst`=1 cycle 8; `row_ready`=0 cycles 8-16; `col_valid`=1 cycles 10-17 with `col_idx` 0..7; out_j at `col_idx`=k equals 8j+k; `block_done` cycle 17; `blk_count`=1.
- Gapped input: rows presented every other cycle (8 rows over 15 cycles) → same column data as above; no `col_valid` before SYNC.
- Back-to-back: 3 blocks, `row_valid` held high → a new block starts every 17 cycles; column 7 data intact when the next block's row 0 is written the same cycle; `blk_count`=3.
- Reset mid-DRAIN: assert `reset` at DRAIN `rd_cnt`=3 → `col_valid` drops next cycle, no `block_done`, `blk_count` unchanged; the next full block outputs correct transposed data.
- Counter wrap: `BLK_CNT_W`=2, run 5 blocks → `blk_count` sequence 1,2,3,0,1.
